// File: rtl/mem_arb_pkg.sv
// Shared types for the unified I/D memory arbiter: FSM state and grant side encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on contention the side opposite to the previous grant wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  gnt_e last,
  output logic valid,
  output gnt_e grant
);

  always_comb begin
    valid = req_i | req_d;
    grant = GNT_I;
    if (req_i && req_d) begin
      grant = (last == GNT_I) ? GNT_D : GNT_I;
    end else if (req_d) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (I) and memory stage (D); one registered
// transaction at a time, one-cycle ack, stall requests for the hazard unit.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_flush,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            stall_if,
  output logic            stall_mem
);

  state_e          state_q, state_d;
  gnt_e            grant_q, grant_d;
  gnt_e            last_q, last_d;
  logic            drop_q, drop_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0] mem_wmask_q, mem_wmask_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;

  logic arb_valid;
  gnt_e arb_grant;
  logic grant_ok;

  // A flush alongside a D request still counts as I contention; a lone flushed fetch gets nothing.
  rr_arb2 u_rr_arb2 (
    .req_i (i_req | i_flush),
    .req_d (d_req),
    .last  (last_q),
    .valid (arb_valid),
    .grant (arb_grant)
  );

  assign grant_ok = arb_valid & ~(i_flush & ~d_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_I;
      last_q      <= GNT_I;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d   = BUSY;
          grant_d   = arb_grant;
          last_d    = arb_grant;
          mem_req_d = 1'b1;
          // A fetch granted while being flushed still runs but is never acknowledged.
          drop_d    = (arb_grant == GNT_I) && i_flush;
          if (arb_grant == GNT_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wmask_d = d_wmask;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            mem_wmask_d = '0;
          end
        end
      end
      BUSY: begin
        if (i_flush && grant_q == GNT_I) begin
          drop_d = 1'b1;
        end
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (grant_q == GNT_I) begin
            i_rdata_d = mem_rdata;
          end else if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    i_ack = (state_q == RESP) && (grant_q == GNT_I) && !drop_q && !i_flush;
    d_ack = (state_q == RESP) && (grant_q == GNT_D);
  end

  assign stall_if  = i_req & ~i_ack & ~i_flush;
  assign stall_mem = d_req & ~d_ack;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester agents, a wait-state memory responder and an ack monitor.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } d_exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_req = 1'b0;
  logic [AW-1:0]   i_addr = '0;
  logic            i_flush = 1'b0;
  logic [DW-1:0]   i_rdata;
  logic            i_ack;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [AW-1:0]   d_addr = '0;
  logic [DW-1:0]   d_wdata = '0;
  logic [DW/8-1:0] d_wmask = '0;
  logic [DW-1:0]   d_rdata;
  logic            d_ack;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_ready = 1'b0;
  logic            stall_if;
  logic            stall_mem;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wait_states = 0;
  bit          ready_tied = 1'b0;
  bit          chk_cmd = 1'b0;
  logic [71:0] exp_cmd = '0;
  logic [31:0] exp_i[$];
  d_exp_t      exp_d[$];
  int          ack_side[$];
  int          ack_cyc[$];
  int          i_todo = 0;
  int          d_todo = 0;
  logic [31:0] d_model_rd = '0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] data_for(input logic [31:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_d(input logic we, input logic [31:0] addr);
    d_exp_t e;
    if (!we) d_model_rd = data_for(addr);
    e.we   = we;
    e.data = d_model_rd;
    exp_d.push_back(e);
  endtask

  task automatic start_i(input int n, input logic [31:0] addr);
    i_addr = addr;
    i_todo = n;
    exp_i.push_back(data_for(addr));
    i_req = 1'b1;
  endtask

  task automatic start_d(input int n, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] wm);
    d_we    = we;
    d_addr  = addr;
    d_wdata = wd;
    d_wmask = wm;
    d_todo  = n;
    push_d(we, addr);
    d_req   = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (i_todo == 0 && d_todo == 0 && exp_i.size() == 0 && exp_d.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1);
  endtask

  // Memory responder: ready after wait_states BUSY cycles, or permanently when tied.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (reset || !mem_req) begin
        cnt = 0;
        mem_ready = ready_tied;
      end else begin
        if (chk_cmd) chk("cmd_stable", {3'b0, mem_we, mem_addr, mem_wdata, mem_wmask}, exp_cmd);
        mem_ready = (cnt >= wait_states) || ready_tied;
        cnt++;
      end
      mem_rdata = data_for(mem_addr);
    end
  end

  // Ack monitor: pops the scoreboard and logs completion order.
  initial forever begin
    @(negedge clk);
    if (i_ack || d_ack) chk("single_ack", i_ack & d_ack, 0);
    if (i_ack) begin
      chk("i_ack_pending", exp_i.size() > 0, 1);
      if (exp_i.size() > 0) chk("i_rdata", i_rdata, exp_i.pop_front());
      ack_side.push_back(0);
      ack_cyc.push_back(cyc);
    end
    if (d_ack) begin
      chk("d_ack_pending", exp_d.size() > 0, 1);
      if (exp_d.size() > 0) begin
        d_exp_t e;
        e = exp_d.pop_front();
        chk("d_rdata", d_rdata, e.data);
      end
      ack_side.push_back(1);
      ack_cyc.push_back(cyc);
    end
  end

  // Requester agents: after an ack either present the next access or drop the request.
  initial forever begin
    @(negedge clk);
    if (i_ack) begin
      #1;
      if (i_todo > 1) begin
        i_todo--;
        i_addr = i_addr + 4;
        exp_i.push_back(data_for(i_addr));
      end else begin
        i_todo = 0;
        i_req = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (d_ack) begin
      #1;
      if (d_todo > 1) begin
        d_todo--;
        d_addr = d_addr + 4;
        push_d(d_we, d_addr);
      end else begin
        d_todo = 0;
        d_req = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    #1 reset = 1'b0;

    // Single fetch with mem_ready tied high.
    ready_tied = 1'b1;
    @(negedge clk);
    #1 start_i(1, 32'h40);
    #1 chk("t1_stall_c0", stall_if, 1);
    @(negedge clk);
    chk("t1_mem_req_c1", mem_req, 1);
    chk("t1_mem_addr_c1", mem_addr, 32'h40);
    chk("t1_mem_we_c1", mem_we, 0);
    chk("t1_stall_c1", stall_if, 1);
    @(negedge clk);
    chk("t1_i_ack_c2", i_ack, 1);
    chk("t1_i_rdata_c2", i_rdata, 32'h0050_0093);
    chk("t1_stall_c2", stall_if, 0);
    wait_idle(10, "t1_idle");
    ready_tied = 1'b0;

    // Simultaneous requests after reset: D first, I right after D's RESP.
    @(negedge clk);
    #1;
    ack_side.delete();
    ack_cyc.delete();
    start_d(1, 1'b0, 32'h100, 32'h0, 4'h0);
    start_i(1, 32'h44);
    wait_idle(30, "t2_idle");
    chk("t2_acks", ack_side.size(), 2);
    if (ack_side.size() == 2) begin
      chk("t2_first_d", ack_side[0], 1);
      chk("t2_second_i", ack_side[1], 0);
      chk("t2_gap", ack_cyc[1] - ack_cyc[0], 3);
    end

    // Continuous contention: strict alternation D,I,D,I,D,I at one access per 3 cycles.
    @(negedge clk);
    #1;
    ack_side.delete();
    ack_cyc.delete();
    start_i(3, 32'h48);
    start_d(3, 1'b0, 32'h300, 32'h0, 4'h0);
    wait_idle(60, "t3_idle");
    chk("t3_acks", ack_side.size(), 6);
    if (ack_side.size() == 6) begin
      for (int k = 0; k < 6; k++) chk("t3_order", ack_side[k], (k % 2 == 0) ? 1 : 0);
      for (int k = 1; k < 6; k++) chk("t3_gap", ack_cyc[k] - ack_cyc[k-1], 3);
    end

    // Store with 3 wait states: command stable, stall_mem until the ack cycle.
    wait_states = 3;
    exp_cmd = {3'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011};
    chk_cmd = 1'b1;
    @(negedge clk);
    #1 start_d(1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011);
    #1 chk("t4_stall_c0", stall_mem, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (d_ack) begin
        chk("t4_ack_cycle", k, 5);
        chk("t4_stall_ack", stall_mem, 0);
        break;
      end
      chk("t4_stall_busy", stall_mem, 1);
    end
    wait_idle(10, "t4_idle");
    chk_cmd = 1'b0;

    // Fetch flushed while BUSY: memory completes, no ack, then a fresh fetch.
    wait_states = 2;
    @(negedge clk);
    #1 start_i(1, 32'h60);
    @(negedge clk);
    chk("t5_mem_req_c1", mem_req, 1);
    #1;
    i_flush = 1'b1;
    void'(exp_i.pop_back());
    i_todo = 0;
    #1 chk("t5_stall_flush", stall_if, 0);
    @(negedge clk);
    chk("t5_mem_req_c2", mem_req, 1);
    #1;
    i_flush = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    chk("t5_mem_req_c3", mem_req, 1);
    chk("t5_stall_c3", stall_if, 0);
    @(negedge clk);
    chk("t5_mem_req_c4", mem_req, 0);
    chk("t5_no_ack_c4", i_ack, 0);
    #1 start_i(1, 32'h80);
    wait_idle(20, "t5_refetch");

    // Flush landing in the RESP cycle suppresses the ack.
    wait_states = 0;
    @(negedge clk);
    #1 start_i(1, 32'h70);
    @(posedge clk);
    @(posedge clk);
    #1;
    i_flush = 1'b1;
    void'(exp_i.pop_back());
    i_todo = 0;
    @(negedge clk);
    chk("t5b_ack_suppressed", i_ack, 0);
    chk("t5b_stall", stall_if, 0);
    #1;
    i_flush = 1'b0;
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while BUSY: command dropped, held load re-arbitrates and completes once.
    wait_states = 4;
    @(negedge clk);
    #1 start_d(1, 1'b0, 32'h180, 32'h0, 4'h0);
    @(negedge clk);
    chk("t6_mem_req_busy", mem_req, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t6_mem_req_rst", mem_req, 0);
    chk("t6_no_d_ack", d_ack, 0);
    chk("t6_i_rdata_clr", i_rdata, 0);
    chk("t6_stall_mem", stall_mem, 1);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_regrant", mem_req, 1);
    chk("t6_regrant_addr", mem_addr, 32'h180);
    wait_idle(30, "t6_idle");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port unified instruction/data memory between the fetch stage (I side) and the memory stage (D side) of the pipelined core. Each access is a registered transaction with a valid/ready handshake to memory. The block returns a one-cycle acknowledge and captured read data to the winning requester. It drives the stall requests that the hazard unit merges with its load-use stalls, and it honours fetch flushes caused by taken branches.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; `DW/8` byte-mask bits

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `i_req`  in  1  fetch request; held until `i_ack` or `i_flush`
- `i_addr`  in  AW  fetch address
- `i_flush`  in  1  fetch cancelled (pcsrcE)
- `i_rdata`  out  DW  fetched word; valid while `i_ack`
- `i_ack`  out  1  one-cycle completion pulse
- `d_req`  in  1  load/store request; held until `d_ack`
- `d_we`  in  1  1 = store
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_wmask`  in  DW/8  store byte enables
- `d_rdata`  out  DW  load data; valid while `d_ack`
- `d_ack`  out  1  one-cycle completion pulse
- `mem_req`  out  1  memory request, registered
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1/AW/DW/DW/8  registered command
- `mem_rdata`  in  DW  read data, sampled when `mem_ready`
- `mem_ready`  in  1  memory accepts/completes the access this cycle
- `stall_if`  out  1  `i_req & ~i_ack & ~i_flush`, combinational
- `stall_mem`  out  1  `d_req & ~d_ack`, combinational

## Operation
- FSM states: IDLE, BUSY, RESP. A `grant` register selects I or D. A `last` register holds the side of the previous grant. A `drop` flag marks a cancelled fetch.
- IDLE:
  - Sole request → grant that side.
  - Both requesting, or `i_flush` high with `d_req` → grant the side opposite to `last`.
  - `i_req & i_flush` with no `d_req` → no grant.
  - On a grant: latch the command into the `mem_*` registers, set `mem_req`=1, update `last`, move to BUSY.
- BUSY:
  - `mem_req` and the command stay stable.
  - On `mem_ready`: capture `mem_rdata` into the side's rdata register, drop `mem_req`, move to RESP.
  - Writes leave rdata undefined-but-stable (previous value kept).
- RESP:
  - Pulse the ack of `grant` for one cycle, unless `drop`.
  - Return to IDLE. No new grant is made in RESP; requesters still show the finished request this cycle.
- Flush:
  - `i_flush` while BUSY with I grant → set `drop`.
  - `i_flush` in RESP with I grant → suppress `i_ack`.
  - The memory transaction always completes; it is never aborted. `drop` clears on return to IDLE.
  - `i_flush` never affects a D transaction.
- Byte mask is forwarded unchanged. The arbiter does no alignment.

## Timing
- Reset values:
  - state IDLE; `mem_req`, `i_ack`, `d_ack` = 0.
  - `last` = I, so the first contention goes to D.
  - `drop` = 0; rdata registers and `mem_*` command registers = 0.
- Latency: request in IDLE at cycle t → `mem_req` high at t+1 → `mem_ready` at earliest t+1 → ack at t+2. Total is 3 cycles per access plus memory wait states.
- Back-to-back throughput: one access per 3 cycles minimum.
- Stall is released in the ack cycle, so the stage advances at the following edge.
- Reset mid-transaction: all state is cleared at the edge. `mem_req` is 0 the next cycle, no ack is issued, and any pending requester re-arbitrates.
- `mem_ready` sampled while not BUSY is ignored.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/BUSY/RESP) and the grant encoding (`GNT_I`=0, `GNT_D`=1).
- Sub-module `rr_arb2`: two-input round-robin pick from `req_i`, `req_d`, `last`; returns the grant. Purely combinational.
- Top-level wiring: `stall_if` and `stall_mem` feed the hazard unit. That unit ORs them into stallF/stallD and into a full-pipe stall for stallE/stallM/stallW.

## Test plan
- After reset, `i_req`=1, `i_addr`=0x40, `mem_ready` tied 1, `mem_rdata`=0x00500093 → `mem_req` at cycle 1, `i_ack`=1 with `i_rdata`=0x00500093 at cycle 2; `stall_if` high cycles 0–1.
- Both `i_req` and `d_req` (load 0x100) in the same cycle after reset → D granted first; I granted in the IDLE following D's RESP.
- Both requesters held continuously for 6 accesses → grants alternate D,I,D,I,D,I; neither side waits more than one transaction.
- Store: `d_we`=1, `d_addr`=0x200, `d_wdata`=0xDEADBEEF, `d_wmask`=0b0011, `mem_ready` delayed 3 cycles → command stable through all BUSY cycles, single `d_ack`, `stall_mem` high until the ack cycle.
- Fetch granted, `i_flush` pulsed in BUSY, `mem_ready` 2 cycles later → memory completes, no `i_ack`, `stall_if` low from the flush cycle; a new `i_req` at 0x80 is then served normally.
- `reset` asserted in BUSY → next cycle `mem_req`=0, no ack, FSM IDLE; a held `d_req` is re-granted.
